block_reducer: RTL and testbench

- Downstream consumer of the 64-entry product buffer filled by the multiplier stage.
- Requests a block drain with EN_blockRead and receives N-bit words on memVal_data/VALID_memVal.
- Reduces each 64-word block to a sum and a maximum.
- Presents results through a 2-deep valid/ready result buffer to the next stage.

---
 rtl/block_reducer_if.sv | 32 +++
 rtl/block_reducer.sv | 131 +++++++++++++
 tb/tb_block_reducer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/block_reducer_if.sv
// Upstream block-drain and downstream result handshake for block_reducer.
// slave is the reducer's view; master is the upstream/downstream environment.
interface block_reducer_if #(
   parameter int N       = 32,
   parameter int LOG_LEN = 6
);
   logic                   EN_blockRead;
   logic                   VALID_memVal;
   logic [N-1:0]           memVal_data;
   logic                   res_valid;
   logic                   res_ready;
   logic [N+LOG_LEN-1:0]   res_sum;
   logic [N-1:0]           res_max;
   logic [7:0]             res_blk_id;
   logic                   ERR_stray;

   modport slave (
      output EN_blockRead,
      input  VALID_memVal, memVal_data,
      output res_valid,
      input  res_ready,
      output res_sum, res_max, res_blk_id, ERR_stray
   );

   modport master (
      input  EN_blockRead,
      output VALID_memVal, memVal_data,
      input  res_valid,
      output res_ready,
      input  res_sum, res_max, res_blk_id, ERR_stray
   );
endinterface

// File: rtl/block_reducer.sv
// Drains BLOCK_LEN-word blocks from the product buffer, reduces each to sum/max,
// and queues results in a 2-entry valid/ready buffer.
module block_reducer #(
   parameter int N         = 32,
   parameter int BLOCK_LEN = 64,
   parameter int LOG_LEN   = 6
) (
   input  logic             clk,
   input  logic             rst,
   block_reducer_if.slave   bus
);
   localparam int SW = N + LOG_LEN;
   localparam logic [LOG_LEN:0] LEN = (LOG_LEN+1)'(BLOCK_LEN);

   typedef enum logic [1:0] {IDLE, REQ, ACCUM, COMMIT} state_t;

   typedef struct packed {
      logic [SW-1:0] sum;
      logic [N-1:0]  max;
      logic [7:0]    id;
   } res_t;

   state_t           state_q, state_d;
   logic             en_q, en_d;
   logic [LOG_LEN:0] beat_q, beat_d, beat_inc;
   logic [SW-1:0]    sum_q, sum_d;
   logic [N-1:0]     max_q, max_d;
   logic [7:0]       id_q, id_d;
   logic             err_q, err_d;
   res_t             head_q, head_d, tail_q, tail_d, new_res;
   logic [1:0]       cnt_q, cnt_d;
   logic             push, pop;

   assign beat_inc = beat_q + 1'b1;
   assign new_res  = '{sum: sum_q, max: max_q, id: id_q};
   assign pop      = (cnt_q != 2'd0) && bus.res_ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      sum_d   = sum_q;
      max_d   = max_q;
      id_d    = id_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.VALID_memVal) err_d = 1'b1;
            // only request when a result slot is guaranteed; upstream cannot stall
            if (cnt_q != 2'd2) state_d = REQ;
         end
         REQ: begin
            if (bus.VALID_memVal) begin
               sum_d   = SW'(bus.memVal_data);
               max_d   = bus.memVal_data;
               beat_d  = (LOG_LEN+1)'(1);
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.VALID_memVal) begin
               sum_d  = sum_q + SW'(bus.memVal_data);
               if (bus.memVal_data > max_q) max_d = bus.memVal_data;
               beat_d = beat_inc;
               if (beat_inc == LEN) state_d = COMMIT;
            end
         end
         COMMIT: begin
            if (bus.VALID_memVal) err_d = 1'b1;
            push    = 1'b1;
            id_d    = id_q + 8'd1;
            beat_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign en_d = (state_d == REQ);

   // head is always the output entry; a simultaneous pop lets a push land in head
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (pop) head_d = tail_q;
      if (push) begin
         if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) head_d = new_res;
         else                                         tail_d = new_res;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         beat_q  <= '0;
         sum_q   <= '0;
         max_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         beat_q  <= beat_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
         id_q    <= id_d;
         err_q   <= err_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.EN_blockRead = en_q;
   assign bus.res_valid    = (cnt_q != 2'd0);
   assign bus.res_sum      = head_q.sum;
   assign bus.res_max      = head_q.max;
   assign bus.res_blk_id   = head_q.id;
   assign bus.ERR_stray    = err_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) push |-> cnt_q != 2'd2);
endmodule

// File: tb/tb_block_reducer.sv
// Directed + randomized bench for block_reducer with a queue-based result model.
module tb_block_reducer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   typedef struct {
      longint sum;
      longint max;
      int     id;
   } exp_t;

   exp_t   q[$];
   int     id_exp  = 0;
   logic   err_exp = 1'b0;

   block_reducer_if #(.N(32), .LOG_LEN(6)) bus();

   block_reducer #(.N(32), .BLOCK_LEN(64), .LOG_LEN(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_en();
      int waited = 0;
      while (bus.EN_blockRead !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      chk("en_req", 64'(bus.EN_blockRead), 64'd1);
   endtask

   // kind: 0 constant, 1 ramp, 2 random; a gap of gap_len idle cycles follows word gap_at
   task automatic drive_words(input int nb, input int kind, input int gap_at, input int gap_len,
                              input logic [31:0] cval, output longint s, output longint m);
      logic [31:0] w;
      s = 0;
      m = 0;
      for (int i = 0; i < nb; i++) begin
         case (kind)
            0:       w = cval;
            1:       w = i[31:0];
            default: w = $urandom;
         endcase
         s += longint'(w);
         if (longint'(w) > m) m = longint'(w);
         bus.VALID_memVal = 1'b1;
         bus.memVal_data  = w;
         step();
         if (i == 0) chk("en_drop", 64'(bus.EN_blockRead), 64'd0);
         bus.VALID_memVal = 1'b0;
         if (i == gap_at) repeat (gap_len) step();
      end
   endtask

   task automatic send_block(input int kind, input int gap_at, input int gap_len, input logic [31:0] cval);
      exp_t e;
      wait_en();
      drive_words(64, kind, gap_at, gap_len, cval, e.sum, e.max);
      e.id   = id_exp;
      id_exp = (id_exp + 1) % 256;
      q.push_back(e);
   endtask

   // exp_wait >= 0 also checks the cycles until res_valid rises
   task automatic pop_result(input int exp_wait);
      int   waited = 0;
      exp_t e;
      while (bus.res_valid !== 1'b1 && waited < 50) begin
         step();
         waited++;
      end
      chk("res_valid", 64'(bus.res_valid), 64'd1);
      if (exp_wait >= 0) chk("latency", 64'(waited), 64'(exp_wait));
      e = q[0];
      chk("res_sum", 64'(bus.res_sum), 64'(e.sum));
      chk("res_max", 64'(bus.res_max), 64'(e.max));
      chk("res_blk_id", 64'(bus.res_blk_id), 64'(e.id));
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      void'(q.pop_front());
   endtask

   initial begin
      logic   en_seen;
      longint ds, dm;
      bus.VALID_memVal = 1'b0;
      bus.memVal_data  = '0;
      bus.res_ready    = 1'b0;
      repeat (3) step();
      chk("rst_en", 64'(bus.EN_blockRead), 64'd0);
      chk("rst_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_sum", 64'(bus.res_sum), 64'd0);
      chk("rst_max", 64'(bus.res_max), 64'd0);
      chk("rst_id", 64'(bus.res_blk_id), 64'd0);
      chk("rst_err", 64'(bus.ERR_stray), 64'd0);
      rst = 1'b0;

      send_block(0, -1, 0, 32'd1);
      pop_result(1);
      send_block(0, -1, 0, 32'hFFFF_FFFF);
      pop_result(1);
      send_block(1, 20, 3, 32'd0);
      pop_result(1);

      // fill both result slots with no downstream acceptance
      send_block(0, -1, 0, 32'd10);
      send_block(2, $urandom_range(0, 62), $urandom_range(0, 4), 32'd0);
      en_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         en_seen |= bus.EN_blockRead;
      end
      chk("en_held_off", 64'(en_seen), 64'd0);
      chk("head_stable", 64'(bus.res_blk_id), 64'(q[0].id));
      bus.VALID_memVal = 1'b1;
      bus.memVal_data  = 32'h55;
      step();
      bus.VALID_memVal = 1'b0;
      err_exp = 1'b1;
      chk("err_stray", 64'(bus.ERR_stray), 64'(err_exp));
      pop_result(0);
      chk("head_next", 64'(bus.res_blk_id), 64'(q[0].id));
      step();
      chk("en_reassert", 64'(bus.EN_blockRead), 64'd1);
      send_block(0, -1, 0, 32'd7);
      pop_result(0);
      pop_result(-1);
      chk("err_sticky", 64'(bus.ERR_stray), 64'(err_exp));

      for (int b = 0; b < 3; b++) begin
         send_block(2, $urandom_range(0, 62), $urandom_range(0, 4), 32'd0);
         pop_result(1);
      end

      // abort a partial block with reset
      wait_en();
      drive_words(30, 0, -1, 0, 32'd9, ds, dm);
      rst = 1'b1;
      q.delete();
      id_exp  = 0;
      err_exp = 1'b0;
      step();
      step();
      chk("rst2_valid", 64'(bus.res_valid), 64'd0);
      chk("rst2_err", 64'(bus.ERR_stray), 64'(err_exp));
      chk("rst2_en", 64'(bus.EN_blockRead), 64'd0);
      rst = 1'b0;
      send_block(0, -1, 0, 32'd2);
      pop_result(1);
      step();
      chk("drained", 64'(bus.res_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
